int_controller: RTL
===================

// Module: int_controller
// PURPOSE
// Programmable interrupt controller between peripheral IRQ lines and the CP0 HWINT[7:2] input.
// Latches edge- or level-mode requests into pending bits and applies a software mask.
// Presents the masked pending vector to CP0; source k drives HWINT[k+2].
// Offers a memory-mapped register window on the bridge for mask/mode setup, W1C acknowledge and claim.
// PARAMETERS
// NUM_SRC       6      number of IRQ sources, 1..6; bits above NUM_SRC-1 read 0 and are never asserted
// DEFAULT_MASK  6'h3F  MASK reset value, 1 = enabled
// DEFAULT_MODE  6'h00  MODE reset value, 1 = edge, 0 = level
// PORTS
// clk     in   1        system clock, all state on posedge
// reset   in   1        asynchronous, active-high; clears all state immediately
// irq_in  in   6        device requests, synchronous to clk
// re      in   1        bridge read strobe; gates rdata and the CLAIM side effect
// we      in   1        bridge write strobe
// addr    in   3        word offset, byte address [4:2]
// wdata   in   32       write data
// rdata   out  32       read data, combinational, 0 when re=0
// hwint   out  6        pend & mask, to CP0 HWINT[7:2]
// BEHAVIOUR
// Reset state: pend=0, irq_prev=0, mask=DEFAULT_MASK, mode=DEFAULT_MODE.
// During reset, hwint=0 and rdata=0.
// Register map:
// - 0 PEND: R; write-1-to-clear on bits[5:0].
// - 1 MASK: RW, bits[5:0].
// - 2 MODE: RW, bits[5:0].
// - 3 FORCE: W; write-1-to-set pend, any mode; reads 0.
// - 4 CLAIM: R; {valid[31], 28'b0, id[2:0]}.
// - 5..7: read 0, writes ignored.
// Edge mode, bit k:
// - irq_prev[k] <= irq_in[k] every cycle.
// - Rising edge (irq_in & ~irq_prev) sets pend[k] at the next posedge.
// - pend[k] holds until W1C or claim.
// Level mode, bit k: pend[k] <= irq_in[k] | force[k] every cycle, so W1C has no effect while the line is high.
// A forced bit in level mode clears on the next cycle unless irq_in is high.
// Latency: irq_in edge/level at cycle N gives hwint at cycle N+1.
// hwint is combinational from registers (pend & mask), with no extra stage.
// Priority for CLAIM: lowest index among (pend & mask) wins.
// - valid=1 with id=k when some bit is set.
// - Otherwise valid=0 and id=3'b111.
// CLAIM side effect: re && addr==4 && valid && mode[id] clears pend[id] at the posedge.
// In level mode, CLAIM does not clear pend[id].
// Set/clear collisions on the same bit in the same cycle (edge or FORCE vs W1C or claim): set wins, so no event is lost.
// W1C and FORCE on different bits in the same cycle are independent.
// Writing MASK does not change pend; masked sources keep pending and appear on hwint when unmasked.
// Writing MODE from level to edge keeps the current pend.
// Writing MODE from edge to level: pend follows irq_in from the next cycle.
// re and we in the same cycle on the same address: the read returns the pre-write value.
// Reset release with irq_in[k]=1 in edge mode counts as a rising edge (irq_prev reset to 0).
// Reset asserted mid-operation: pending edges are discarded and hwint drops asynchronously.
// STRUCTURE
// Shared include file ("../include/interrupt.v"):
// - `INTC_PEND..`INTC_CLAIM offset macros.
// - `TYPE_INT width macro, shared with CP0.
// - CLAIM_NONE = 3'b111.
// Sub-module int_prio_enc: 6-bit lowest-index-first priority encoder, outputs {valid, id}.
// Everything else (registers, decode, set/clear logic) stays flat in int_controller.
// TESTING
// 1 Reset: reset pulse -> hwint=0; read MASK=0x3F, MODE=0, PEND=0; CLAIM=0x0000_0007.
// 2 Level: irq_in=6'b000100 -> hwint=6'b000100 one cycle later.
//   Write PEND=0x04 while the line is held high -> still 0x04.
//   Drop irq_in -> hwint=0 next cycle.
// 3 Edge+claim: MODE=0x3F; pulse irq_in[1] and irq_in[4] for 1 cycle.
//   -> PEND=0x12.
//   -> CLAIM read returns 0x8000_0001, then PEND=0x10.
//   -> CLAIM returns 0x8000_0004, then 0x0000_0007.
// 4 Mask: MASK=0x00 with an edge on irq_in[0] -> PEND=0x01, hwint=0.
//   MASK=0x01 -> hwint=0x01 the same cycle the register updates.
// 5 Collision: edge mode; new rising edge on bit 3 in the same cycle as W1C of PEND bit 3 -> PEND bit 3 remains 1.
//   FORCE=0x20 -> hwint[5]=1 next cycle.
// 6 Async reset: pend=0x3F, assert reset between clock edges -> hwint=0 before the next posedge.
//   Release with irq_in[0]=1 in edge mode -> PEND=0x01 after the first posedge.

Source files
------------

// File: rtl/int_controller_pkg.sv
// Shared constants and types for the programmable interrupt controller:
// register offsets, interrupt vector width, and the CLAIM word layout.
package int_controller_pkg;

    // Register window word offsets (byte address [4:2])
    localparam logic [2:0] INTC_PEND  = 3'd0;
    localparam logic [2:0] INTC_MASK  = 3'd1;
    localparam logic [2:0] INTC_MODE  = 3'd2;
    localparam logic [2:0] INTC_FORCE = 3'd3;
    localparam logic [2:0] INTC_CLAIM = 3'd4;

    // Width of the hardware interrupt vector shared with CP0 HWINT[7:2]
    localparam int TYPE_INT = 6;

    // Id reported by CLAIM when nothing is pending and enabled
    localparam logic [2:0] CLAIM_NONE = 3'b111;

    typedef struct packed {
        logic       valid;
        logic [2:0] id;
    } claim_t;

    // Pack a claim result into the 32-bit CLAIM register layout
    function automatic logic [31:0] claim_word(input claim_t c);
        return {c.valid, 28'h0, c.id};
    endfunction

endpackage

// File: rtl/int_controller_prio_enc.sv
// Lowest-index-first priority encoder over the enabled pending vector.
// Produces {valid, id}; id is CLAIM_NONE when no request is set.
module int_prio_enc
    import int_controller_pkg::*;
(
    input  logic [TYPE_INT-1:0] req,
    output logic                valid,
    output logic [2:0]          id
);

    // Pick the lowest set request bit
    always_comb begin
        valid = 1'b1;
        id    = CLAIM_NONE;
        casez (req)
            6'b?????1: id = 3'd0;
            6'b????10: id = 3'd1;
            6'b???100: id = 3'd2;
            6'b??1000: id = 3'd3;
            6'b?10000: id = 3'd4;
            6'b100000: id = 3'd5;
            default: begin
                valid = 1'b0;
                id    = CLAIM_NONE;
            end
        endcase
    end

endmodule

// File: rtl/int_controller.sv
// Programmable interrupt controller feeding CP0 HWINT[7:2].
// Latches edge- or level-mode requests into pending bits, applies a
// software mask, and exposes a bridge register window for setup,
// write-1-to-clear acknowledge, software force and claim.
module int_controller
    import int_controller_pkg::*;
#(
    parameter int          NUM_SRC      = 6,
    parameter logic [5:0]  DEFAULT_MASK = 6'h3F,
    parameter logic [5:0]  DEFAULT_MODE = 6'h00
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [5:0]  irq_in,
    input  logic        re,
    input  logic        we,
    input  logic [2:0]  addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic [5:0]  hwint
);

    // Bits at or above NUM_SRC are tied off everywhere
    localparam logic [5:0] SRC_MASK = 6'((7'd1 << NUM_SRC) - 7'd1);

    logic [5:0] pend_q, pend_d;
    logic [5:0] mask_q, mask_d;
    logic [5:0] mode_q, mode_d;
    logic [5:0] irq_prev_q, irq_prev_d;

    logic [5:0] rise_s;
    logic [5:0] w1c_s;
    logic [5:0] force_s;
    logic [5:0] claim_clr_s;
    logic [5:0] set_s;
    logic [5:0] clr_s;
    logic [5:0] enabled_s;
    logic       prio_valid_s;
    logic [2:0] prio_id_s;
    logic       claim_take_s;
    claim_t     claim_s;
    logic [31:0] rdata_s;

    // Upper write data bits carry no register state
    logic [25:0] unused_wdata_s;
    assign unused_wdata_s = wdata[31:6];

    assign enabled_s = pend_q & mask_q;

    int_prio_enc u_prio (
        .req   (enabled_s),
        .valid (prio_valid_s),
        .id    (prio_id_s)
    );

    // Decode bridge accesses into per-bit set and clear requests
    always_comb begin
        rise_s       = irq_in & ~irq_prev_q & SRC_MASK;
        w1c_s        = 6'h00;
        force_s      = 6'h00;
        claim_clr_s  = 6'h00;
        claim_take_s = re && (addr == INTC_CLAIM) && prio_valid_s;
        if (we && (addr == INTC_PEND)) begin
            w1c_s = wdata[5:0] & SRC_MASK;
        end else begin
            w1c_s = 6'h00;
        end
        if (we && (addr == INTC_FORCE)) begin
            force_s = wdata[5:0] & SRC_MASK;
        end else begin
            force_s = 6'h00;
        end
        for (int k = 0; k < 6; k++) begin
            if (claim_take_s && (prio_id_s == 3'(k))) begin
                claim_clr_s[k] = 1'b1;
            end else begin
                claim_clr_s[k] = 1'b0;
            end
        end
        set_s = rise_s | force_s;
        clr_s = w1c_s | claim_clr_s;
    end

    // Next pending state: edge bits latch with set-over-clear, level bits track the line
    always_comb begin
        pend_d = pend_q;
        for (int k = 0; k < 6; k++) begin
            if (mode_q[k]) begin
                pend_d[k] = set_s[k] | (pend_q[k] & ~clr_s[k]);
            end else begin
                pend_d[k] = (irq_in[k] & SRC_MASK[k]) | force_s[k];
            end
        end
        pend_d     = pend_d & SRC_MASK;
        irq_prev_d = irq_in & SRC_MASK;
    end

    // Next MASK and MODE from bridge writes
    always_comb begin
        mask_d = mask_q;
        mode_d = mode_q;
        if (we && (addr == INTC_MASK)) begin
            mask_d = wdata[5:0] & SRC_MASK;
        end else begin
            mask_d = mask_q;
        end
        if (we && (addr == INTC_MODE)) begin
            mode_d = wdata[5:0] & SRC_MASK;
        end else begin
            mode_d = mode_q;
        end
    end

    // State registers, cleared immediately on reset
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pend_q     <= 6'h00;
            irq_prev_q <= 6'h00;
            mask_q     <= DEFAULT_MASK & SRC_MASK;
            mode_q     <= DEFAULT_MODE & SRC_MASK;
        end else begin
            pend_q     <= pend_d;
            irq_prev_q <= irq_prev_d;
            mask_q     <= mask_d;
            mode_q     <= mode_d;
        end
    end

    // Read mux; always returns pre-write values and is silent during reset
    always_comb begin
        rdata_s       = 32'h0;
        claim_s.valid = prio_valid_s;
        claim_s.id    = prio_id_s;
        if (re && !reset) begin
            case (addr)
                INTC_PEND:  rdata_s = {26'h0, pend_q};
                INTC_MASK:  rdata_s = {26'h0, mask_q};
                INTC_MODE:  rdata_s = {26'h0, mode_q};
                INTC_CLAIM: rdata_s = claim_word(claim_s);
                default:    rdata_s = 32'h0;
            endcase
        end else begin
            rdata_s = 32'h0;
        end
    end

    assign rdata = rdata_s;
    assign hwint = reset ? 6'h00 : enabled_s;

endmodule
